// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and defaults for the fetch sequencer.
//   fetch_state_t    - sequencer state encoding
//   RESET_PC_DEFAULT - default program counter after reset
//   STEP_DEFAULT     - default byte increment per sequential fetch
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALTED
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned STEP_DEFAULT     = 4;

endpackage

// File: rtl/pc_reg_en.sv
// pc_reg_en: WIDTH-bit register with synchronous active-high reset and load enable.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, loads RESET_VAL
//   en    - load enable
//   d     - next value, captured when en=1
//   q     - register contents
module pc_reg_en #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the program counter and sequences instruction fetch.
// Issues a request at the PC, holds the returned word until decode accepts it, then
// advances by STEP. Redirects override everything except reset; halt is honoured
// only when a held instruction is accepted.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   imem_req/imem_addr      - fetch request and address (Moore, from state and pc)
//   imem_ack/imem_rdata     - memory response, valid only in FETCH
//   inst_valid/inst/inst_pc - registered instruction handed to decode
//   inst_ready              - decode accepts the held instruction
//   redirect/redirect_pc    - branch/jump target load
//   halt/halted             - stop after acceptance / sequencer is halted
// Optional feature macro PC_FETCH_PERF_EN adds saturating fetch_count and stall_count.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned      STEP     = STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt,
`ifdef PC_FETCH_PERF_EN
  output logic [31:0]      fetch_count,
  output logic [31:0]      stall_count,
`endif
  output logic             halted
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_en;
  logic             capture;
  logic             inst_valid_q, inst_valid_d;

  // Redirect wins over any ack or acceptance in the same cycle.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    pc_d         = pc_q + WIDTH'(STEP);
    capture      = 1'b0;
    inst_valid_d = inst_valid_q;
    if (redirect) begin
      state_d      = FETCH;
      pc_en        = 1'b1;
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: begin
          if (imem_ack) begin
            capture      = 1'b1;
            pc_en        = 1'b1;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid_d = 1'b0;
            state_d      = halt ? HALTED : FETCH;
          end
        end
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  pc_reg_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  pc_reg_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL ('0)
  ) u_inst_pc (
    .clk   (clk),
    .reset (reset),
    .en    (capture),
    .d     (pc_q),
    .q     (inst_pc)
  );

  pc_reg_en #(
    .WIDTH     (32),
    .RESET_VAL ('0)
  ) u_inst (
    .clk   (clk),
    .reset (reset),
    .en    (capture),
    .d     (imem_rdata),
    .q     (inst)
  );

  always_comb begin
    imem_req   = (state_q == FETCH);
    imem_addr  = pc_q;
    halted     = (state_q == HALTED);
    inst_valid = inst_valid_q;
  end

`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_count_q, stall_count_q;
  logic        stall;

  // Stalls count regardless of a concurrent redirect: the cycle was still spent waiting.
  assign stall = ((state_q == FETCH) && !imem_ack) || ((state_q == HOLD) && !inst_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (capture && (fetch_count_q != 32'hFFFF_FFFF)) fetch_count_q <= fetch_count_q + 32'd1;
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
